// File: rtl/ps2_scancode_assembler.sv
// Folds PS/2 Set-2 byte sequences into single {ext, brk, code} key events, tracks modifier
// keys and holds each event in a one-deep valid/ready slot with sticky overrun reporting.
module ps2_scancode_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  PAUSE_CODE     = 8'h77
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_brk,
  output logic       out_sys,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       overrun,
  input  logic       ovr_clear,
  output logic       err_timeout
);

  localparam int unsigned TimerW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StPause} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              timeout;
  logic              evt_fire, evt_ext, evt_brk, evt_sys;
  logic [7:0]        evt_code;
  logic              mod_upd, shift_d, ctrl_d, alt_d;
  logic              is_sys, is_fake;

  assign is_sys  = in_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  assign is_fake = (in_data == 8'h12) || (in_data == 8'h59);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timeout  = 1'b0;
    evt_fire = 1'b0;
    evt_code = in_data;
    evt_ext  = 1'b0;
    evt_brk  = 1'b0;
    evt_sys  = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        StIdle: begin
          if (in_data == 8'hE0) begin
            state_d = StE0;
          end else if (in_data == 8'hF0) begin
            state_d = StF0;
          end else if (in_data == 8'hE1) begin
            state_d = StPause;
            cnt_d   = 3'd7;
          end else begin
            evt_fire = 1'b1;
            evt_sys  = is_sys;
          end
        end
        StE0: begin
          if (in_data == 8'hF0) begin
            state_d = StE0F0;
          end else if (in_data != 8'hE0 && in_data != 8'hE1) begin
            state_d  = StIdle;
            evt_fire = !is_fake;
            evt_ext  = 1'b1;
          end
        end
        StF0: begin
          state_d  = StIdle;
          evt_fire = 1'b1;
          evt_brk  = 1'b1;
        end
        StE0F0: begin
          state_d  = StIdle;
          evt_fire = !is_fake;
          evt_ext  = 1'b1;
          evt_brk  = 1'b1;
        end
        StPause: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d  = StIdle;
            evt_fire = 1'b1;
            evt_ext  = 1'b1;
            evt_code = PAUSE_CODE;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && timer_q == TimerLast) begin
      state_d = StIdle;
      timeout = 1'b1;
    end
  end

  assign timer_d = (in_valid || state_q == StIdle || timeout) ? '0 : timer_q + 1'b1;

  // Modifiers follow the key stream even when the event itself is dropped.
  assign mod_upd = evt_fire && !evt_sys && (state_q != StPause);

  always_comb begin
    shift_d = mod_shift;
    ctrl_d  = mod_ctrl;
    alt_d   = mod_alt;
    if (mod_upd) begin
      if (!evt_ext && (evt_code == 8'h12 || evt_code == 8'h59)) shift_d = !evt_brk;
      if (evt_code == 8'h14) ctrl_d = !evt_brk;
      if (evt_code == 8'h11) alt_d = !evt_brk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      timer_q     <= '0;
      err_timeout <= 1'b0;
      mod_shift   <= 1'b0;
      mod_ctrl    <= 1'b0;
      mod_alt     <= 1'b0;
      out_valid   <= 1'b0;
      out_code    <= 8'h00;
      out_ext     <= 1'b0;
      out_brk     <= 1'b0;
      out_sys     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      err_timeout <= timeout;
      mod_shift   <= shift_d;
      mod_ctrl    <= ctrl_d;
      mod_alt     <= alt_d;
      if (evt_fire && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_code  <= evt_code;
        out_ext   <= evt_ext;
        out_brk   <= evt_brk;
        out_sys   <= evt_sys;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovr_clear) begin
        overrun <= 1'b0;
      end else if (evt_fire && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
